// File: rtl/ttl_decode_strobe_pkg.sv
// Shared types and helpers for the 1-of-N decoder and chip-select strobe engine.
// Pure declarations, no latency or flow control.
package ttl_decode_pkg;

    localparam int MAX_SEL_W = 6;
    localparam int MAX_OUT   = 1 << MAX_SEL_W;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HOLDOFF
    } state_t;

    // Codes at or above 2**sel_w decode to nothing.
    function automatic logic [MAX_OUT-1:0] onehot(input logic [MAX_SEL_W-1:0] sel, input int sel_w);
        onehot = '0;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (i < (1 << sel_w) && sel == MAX_SEL_W'(i)) begin
                onehot[i] = 1'b1;
            end
        end
    endfunction

    // Level of an output line that is not selected.
    function automatic logic idle_level(input int active_low);
        return active_low != 0;
    endfunction

    function automatic int cnt_width(input int strobe_cyc, input int holdoff_cyc);
        int m;
        m = (strobe_cyc > holdoff_cyc) ? strobe_cyc : holdoff_cyc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ttl_decode_strobe_if.sv
// Request/enable inputs and decoded strobe outputs of the decoder, grouped as one port.
// Single-cycle req qualifier; no backpressure, refusals are reported on rej.
interface ttl_decode_strobe_if #(
    parameter int SEL_W = 3
);
    localparam int OUT_N = 1 << SEL_W;

    logic [SEL_W-1:0] sel;
    logic             g1_n;
    logic             g2_n;
    logic             g3;
    logic             req;
    logic [OUT_N-1:0] q;
    logic             busy;
    logic             done;
    logic             rej;

    modport master (
        output sel, g1_n, g2_n, g3, req,
        input  q, busy, done, rej
    );

    modport slave (
        input  sel, g1_n, g2_n, g3, req,
        output q, busy, done, rej
    );

endinterface

// File: rtl/ttl_decode_strobe_onehot.sv
// Combinational select-code to one-hot decode, gated by enable; active-high result.
// Zero latency; no flow control.
module ttl_decode_onehot
    import ttl_decode_pkg::*;
#(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic                  ena,
    output logic [(1<<SEL_W)-1:0] oh
);
    localparam int OUT_N = 1 << SEL_W;

    assign oh = ena ? OUT_N'(onehot(MAX_SEL_W'(sel), SEL_W)) : '0;

endmodule

// File: rtl/ttl_decode_strobe.sv
// 1-of-2^SEL_W decoder with 74F138-style enables driving a timed chip-select strobe plus hold-off.
// q follows an accepted req by 1 cycle; no backpressure: req while busy or disabled pulses rej.
module ttl_decode_strobe
    import ttl_decode_pkg::*;
#(
    parameter int SEL_W       = 3,
    parameter int ACTIVE_LOW  = 1,
    parameter int STROBE_CYC  = 2,
    parameter int HOLDOFF_CYC = 1
) (
    input logic                clk,
    input logic                reset_n,
    ttl_decode_strobe_if.slave bus
);
    localparam int               OUT_N     = 1 << SEL_W;
    localparam int               CNT_W     = cnt_width(STROBE_CYC, HOLDOFF_CYC);
    localparam logic [CNT_W-1:0] STB_LOAD  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0);
    localparam logic             IDLE_LVL  = idle_level(ACTIVE_LOW);
    localparam logic [OUT_N-1:0] Q_IDLE    = {OUT_N{IDLE_LVL}};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] sel_q;
    logic [OUT_N-1:0] q_r;
    logic             done_r;
    logic             rej_r;

    logic             ena;
    logic             idle;
    logic [SEL_W-1:0] dec_sel;
    logic             dec_ena;
    logic [OUT_N-1:0] oh;

    assign ena  = ~bus.g1_n & ~bus.g2_n & bus.g3;
    assign idle = (state == IDLE);

    // Once a strobe is running the decoder only ever sees the latched code.
    assign dec_sel = idle ? bus.sel : sel_q;
    assign dec_ena = idle ? ena : 1'b1;

    ttl_decode_onehot #(
        .SEL_W (SEL_W)
    ) u_dec (
        .sel (dec_sel),
        .ena (dec_ena),
        .oh  (oh)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sel_q  <= '0;
            q_r    <= Q_IDLE;
            done_r <= 1'b0;
            rej_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            rej_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        if (ena) begin
                            sel_q <= bus.sel;
                            cnt   <= STB_LOAD;
                            q_r   <= oh ^ Q_IDLE;
                            state <= ACTIVE;
                        end else begin
                            rej_r <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    rej_r <= bus.req;
                    // Losing the enable ends the strobe early without reporting done.
                    if (!ena || cnt == '0) begin
                        q_r    <= Q_IDLE;
                        done_r <= ena;
                        if (HOLDOFF_CYC > 0) begin
                            cnt   <= HOLD_LOAD;
                            state <= HOLDOFF;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        q_r <= oh ^ Q_IDLE;
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLDOFF: begin
                    rej_r <= bus.req;
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    q_r   <= Q_IDLE;
                end
            endcase
        end
    end

    assign bus.q    = q_r;
    assign bus.busy = ~idle;
    assign bus.done = done_r;
    assign bus.rej  = rej_r;

endmodule
